// File: rtl/playlist_mcu.sv
// playlist_mcu: playback controller between the debounced buttons and the song reader.
// Turns play/pause, next, prev and song_done pulses into a play enable, a song index
// and a one-cycle reset_play restart pulse. Supports four end-of-song modes and
// flags the end of the playlist with list_end.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   play_pause  pulse, toggle play/pause
//   next        pulse, skip forward (shuffle pick in SHUFFLE mode)
//   prev        pulse, skip backward (always sequential)
//   song_done   pulse from note player, current song finished
//   mode        00 single, 01 loop-all, 10 repeat-one, 11 shuffle
//   play        high while a song is playing
//   song        current song index, 0..NUM_SONGS-1
//   reset_play  one-cycle restart pulse for the song reader/note player
//   list_end    one-cycle pulse when the last song finishes in single/loop-all
module playlist_mcu #(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_W    = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              prev,
  input  logic              song_done,
  input  logic [1:0]        mode,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_play,
  output logic              list_end
);

  localparam int unsigned     ExtW    = SONG_W + 1;
  localparam logic [ExtW-1:0] NumExt  = ExtW'(NUM_SONGS);
  localparam logic [ExtW-1:0] LastExt = ExtW'(NUM_SONGS - 1);

  localparam logic [1:0] ModeSingle  = 2'b00;
  localparam logic [1:0] ModeLoopAll = 2'b01;
  localparam logic [1:0] ModeShuffle = 2'b11;

  typedef enum logic [2:0] {StReset, StPause, StPlay, StSkip, StDone} state_e;

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              running_q, running_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              play_q, reset_play_q, list_end_q, list_end_d;

  logic [ExtW-1:0] song_ext, inc_sum, dec_sum, song_inc, song_dec, cand, song_shuf, next_pick;
  logic [8:0]      lfsr_mod;

  // Song arithmetic one bit wider than song; sums stay below 2*NUM_SONGS so a single
  // conditional subtract is a full modulo reduction.
  always_comb begin
    song_ext  = {1'b0, song_q};
    inc_sum   = song_ext + ExtW'(1);
    song_inc  = (inc_sum >= NumExt) ? inc_sum - NumExt : inc_sum;
    dec_sum   = song_ext + LastExt;
    song_dec  = (dec_sum >= NumExt) ? dec_sum - NumExt : dec_sum;
    lfsr_mod  = {1'b0, lfsr_q} % 9'(NUM_SONGS);
    cand      = ExtW'(lfsr_mod);
    // Never pick the current song again.
    song_shuf = (cand == song_ext) ? song_inc : cand;
    next_pick = (mode == ModeShuffle) ? song_shuf : song_inc;
  end

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    running_d  = running_q;
    list_end_d = 1'b0;
    // x^8+x^6+x^5+x^4+1, free-running
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    unique case (state_q)
      StReset: state_d = StPause;
      StPause: begin
        if (play_pause) begin
          state_d = StPlay;
        end else if (next || prev) begin
          state_d   = StSkip;
          running_d = 1'b0;
          song_d    = SONG_W'(next ? next_pick : song_dec);
        end
      end
      StPlay: begin
        if (next || prev) begin
          state_d   = StSkip;
          running_d = 1'b1;
          song_d    = SONG_W'(next ? next_pick : song_dec);
        end else if (song_done) begin
          state_d    = StDone;
          list_end_d = (song_ext == LastExt) && !mode[1];
          // running doubles as the resume target out of StDone
          running_d  = (mode != ModeSingle);
          case (mode)
            ModeLoopAll: song_d = SONG_W'(song_inc);
            ModeShuffle: song_d = SONG_W'(song_shuf);
            default:     song_d = song_q;
          endcase
        end else if (play_pause) begin
          state_d = StPause;
        end
      end
      StSkip, StDone: state_d = running_q ? StPlay : StPause;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StReset;
      song_q       <= '0;
      running_q    <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      play_q       <= 1'b0;
      reset_play_q <= 1'b1;
      list_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      running_q    <= running_d;
      lfsr_q       <= lfsr_d;
      // Outputs registered alongside the state they decode.
      play_q       <= (state_d == StPlay);
      reset_play_q <= (state_d == StSkip) || (state_d == StDone) || (state_d == StReset);
      list_end_q   <= list_end_d;
    end
  end

  assign play       = play_q;
  assign song       = song_q;
  assign reset_play = reset_play_q;
  assign list_end   = list_end_q;

endmodule

// File: tb/tb_playlist_mcu.sv
// Bench for playlist_mcu: a 4-song instance for the sequential features and a 5-song
// instance for shuffle. Expected outputs are queued as stimulus is driven and popped
// once the DUT has reacted.
module tb_playlist_mcu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_pause = 1'b0, next = 1'b0, prev = 1'b0, song_done = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       play4, rp4, le4, play5, rp5, le5;
  logic [1:0] song4;
  logic [2:0] song5;
  logic [5:0] obs4, obs5;
  logic [7:0] m_lfsr;
  int         vectors = 0;
  int         miscompares = 0;

  typedef struct {string name; logic [3:0] in; logic [1:0] md; logic [4:0] exp;} vec_t;
  typedef struct {string name; logic [5:0] exp;} sb_t;

  sb_t sb[$];

  assign obs4 = {1'b0, play4, song4, rp4, le4};
  assign obs5 = {play5, song5, rp5, le5};

  always #5 clk = ~clk;

  playlist_mcu #(.NUM_SONGS(4), .SONG_W(2), .LFSR_SEED(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
    .song_done(song_done), .mode(mode), .play(play4), .song(song4),
    .reset_play(rp4), .list_end(le4)
  );

  playlist_mcu #(.NUM_SONGS(5), .SONG_W(3), .LFSR_SEED(8'hA5)) dut5 (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
    .song_done(song_done), .mode(mode), .play(play5), .song(song5),
    .reset_play(rp5), .list_end(le5)
  );

  // Reference shuffle LFSR built from the polynomial x^8+x^6+x^5+x^4+1.
  always @(posedge clk or negedge reset)
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  function automatic vec_t v(string n, logic [3:0] i, logic [1:0] m, logic [4:0] x);
    v.name = n; v.in = i; v.md = m; v.exp = x;
  endfunction

  function automatic sb_t sbe(string n, logic [5:0] x);
    sbe.name = n; sbe.exp = x;
  endfunction

  // Inputs {play_pause, next, prev, song_done} held for one clock, then cleared.
  task automatic drive(input logic [3:0] in, input logic [1:0] md);
    @(negedge clk);
    {play_pause, next, prev, song_done} = in;
    mode = md;
    @(posedge clk);
    #1;
    {play_pause, next, prev, song_done} = 4'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    sb.push_back(sbe("reset_low", 6'b0_0_00_1_0));
    #2;
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(sbe("release_no_edge", 6'b0_0_00_1_0));
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
    sb.push_back(sbe("first_edge_pause", 6'b0_0_00_0_0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
  endtask

  task automatic test_play_pause();
    vec_t tbl[$];
    sb_t  e;
    tbl.push_back(v("pp_play",   4'b1000, 2'd0, 5'b1_00_0_0));
    tbl.push_back(v("pp_pause",  4'b1000, 2'd0, 5'b0_00_0_0));
    tbl.push_back(v("pp_resume", 4'b1000, 2'd0, 5'b1_00_0_0));
    foreach (tbl[i]) begin
      sb.push_back(sbe(tbl[i].name, {1'b0, tbl[i].exp}));
      drive(tbl[i].in, tbl[i].md);
      e = sb.pop_front();
      vectors++;
      if (obs4 !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t tbl[$];
    sb_t  e;
    tbl.push_back(v("next_0_1",    4'b0100, 2'd0, 5'b0_01_1_0));
    tbl.push_back(v("skip_ret1",   4'b0000, 2'd0, 5'b1_01_0_0));
    tbl.push_back(v("next_1_2",    4'b0100, 2'd0, 5'b0_10_1_0));
    tbl.push_back(v("skip_ret2",   4'b0000, 2'd0, 5'b1_10_0_0));
    tbl.push_back(v("next_2_3",    4'b0100, 2'd0, 5'b0_11_1_0));
    tbl.push_back(v("skip_ret3",   4'b0000, 2'd0, 5'b1_11_0_0));
    tbl.push_back(v("next_wrap",   4'b0100, 2'd0, 5'b0_00_1_0));
    tbl.push_back(v("wrap_play",   4'b0000, 2'd0, 5'b1_00_0_0));
    tbl.push_back(v("pause",       4'b1000, 2'd0, 5'b0_00_0_0));
    tbl.push_back(v("prev_wrap",   4'b0010, 2'd0, 5'b0_11_1_0));
    tbl.push_back(v("prev_paused", 4'b0000, 2'd0, 5'b0_11_0_0));
    tbl.push_back(v("stay_paused", 4'b0000, 2'd0, 5'b0_11_0_0));
    foreach (tbl[i]) begin
      sb.push_back(sbe(tbl[i].name, {1'b0, tbl[i].exp}));
      drive(tbl[i].in, tbl[i].md);
      e = sb.pop_front();
      vectors++;
      if (obs4 !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
      end
    end
  endtask

  task automatic test_song_done_modes();
    vec_t tbl[$];
    sb_t  e;
    tbl.push_back(v("done_paused_ign", 4'b0001, 2'd0, 5'b0_11_0_0));
    tbl.push_back(v("play3",           4'b1000, 2'd0, 5'b1_11_0_0));
    tbl.push_back(v("single_done",     4'b0001, 2'd0, 5'b0_11_1_1));
    tbl.push_back(v("single_pause",    4'b0000, 2'd0, 5'b0_11_0_0));
    tbl.push_back(v("play3b",          4'b1000, 2'd1, 5'b1_11_0_0));
    tbl.push_back(v("loop_done",       4'b0001, 2'd1, 5'b0_00_1_1));
    tbl.push_back(v("loop_play",       4'b0000, 2'd1, 5'b1_00_0_0));
    tbl.push_back(v("back3",           4'b0010, 2'd1, 5'b0_11_1_0));
    tbl.push_back(v("back3_play",      4'b0000, 2'd1, 5'b1_11_0_0));
    tbl.push_back(v("repeat_done",     4'b0001, 2'd2, 5'b0_11_1_0));
    tbl.push_back(v("repeat_play",     4'b0000, 2'd2, 5'b1_11_0_0));
    tbl.push_back(v("loop_done2",      4'b0001, 2'd1, 5'b0_00_1_1));
    tbl.push_back(v("loop_play2",      4'b0000, 2'd1, 5'b1_00_0_0));
    tbl.push_back(v("loop_mid_done",   4'b0001, 2'd1, 5'b0_01_1_0));
    tbl.push_back(v("loop_mid_play",   4'b0000, 2'd1, 5'b1_01_0_0));
    foreach (tbl[i]) begin
      sb.push_back(sbe(tbl[i].name, {1'b0, tbl[i].exp}));
      drive(tbl[i].in, tbl[i].md);
      e = sb.pop_front();
      vectors++;
      if (obs4 !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    vec_t tbl[$];
    sb_t  e;
    tbl.push_back(v("next_and_done", 4'b0101, 2'd1, 5'b0_10_1_0));
    tbl.push_back(v("nd_play",       4'b0000, 2'd1, 5'b1_10_0_0));
    tbl.push_back(v("pp_and_prev",   4'b1010, 2'd1, 5'b0_01_1_0));
    tbl.push_back(v("pp_prev_play",  4'b0000, 2'd1, 5'b1_01_0_0));
    tbl.push_back(v("next_skip",     4'b0100, 2'd1, 5'b0_10_1_0));
    tbl.push_back(v("pp_in_skip",    4'b1000, 2'd1, 5'b1_10_0_0));
    tbl.push_back(v("pp_dropped",    4'b0000, 2'd1, 5'b1_10_0_0));
    tbl.push_back(v("done_2_3",      4'b0001, 2'd1, 5'b0_11_1_0));
    tbl.push_back(v("done_in_done",  4'b0001, 2'd1, 5'b1_11_0_0));
    tbl.push_back(v("still_play",    4'b0000, 2'd1, 5'b1_11_0_0));
    foreach (tbl[i]) begin
      sb.push_back(sbe(tbl[i].name, {1'b0, tbl[i].exp}));
      drive(tbl[i].in, tbl[i].md);
      e = sb.pop_front();
      vectors++;
      if (obs4 !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_skip();
    sb_t e;
    sb.push_back(sbe("prev_skip", 6'b0_0_10_1_0));
    drive(4'b0010, 2'd1);
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
    #1;
    reset = 1'b0;
    sb.push_back(sbe("reset_async", 6'b0_0_00_1_0));
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(sbe("reset_release", 6'b0_0_00_0_0));
    drive(4'b0000, 2'd1);
    e = sb.pop_front();
    vectors++;
    if (obs4 !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", e.name, obs4, e.exp);
    end
  endtask

  // Two runs from the same seed, each predicted from the reference LFSR, so both runs
  // must produce the same sequence.
  task automatic test_shuffle();
    logic [2:0] cur, cand, pick;
    sb_t        e;
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      mode  = 2'd3;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      cur   = 3'd0;
      sb.push_back(sbe($sformatf("shuf_start_r%0d", run), 6'b1_000_0_0));
      drive(4'b1000, 2'd3);
      e = sb.pop_front();
      vectors++;
      if (obs5 !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b, want %b", e.name, obs5, e.exp);
      end
      for (int i = 0; i < 51; i++) begin
        cand = 3'(m_lfsr % 8'd5);
        pick = (cand == cur) ? ((cur == 3'd4) ? 3'd0 : cur + 3'd1) : cand;
        // 50 song_done pulses, then one shuffled next
        if (i < 50) begin
          sb.push_back(sbe($sformatf("shuf_done_r%0d_%0d", run, i), {1'b0, pick, 2'b10}));
          drive(4'b0001, 2'd3);
        end else begin
          sb.push_back(sbe($sformatf("shuf_next_r%0d", run), {1'b0, pick, 2'b10}));
          drive(4'b0100, 2'd3);
        end
        e = sb.pop_front();
        vectors++;
        if (obs5 !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %b, want %b", e.name, obs5, e.exp);
        end
        vectors++;
        if (song5 >= 3'd5 || song5 == cur) begin
          miscompares++;
          $display("FAIL shuf_norepeat_r%0d_%0d: got song %0d after %0d, want <5 and new",
                   run, i, song5, cur);
        end
        cur = pick;
        sb.push_back(sbe($sformatf("shuf_resume_r%0d_%0d", run, i), {1'b1, pick, 2'b00}));
        drive(4'b0000, 2'd3);
        e = sb.pop_front();
        vectors++;
        if (obs5 !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %b, want %b", e.name, obs5, e.exp);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_play_pause();
    test_wrap();
    test_song_done_modes();
    test_simultaneous();
    test_reset_mid_skip();
    test_shuffle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
